// File: rtl/zbt_stream_arbiter_pkg.sv
// Shared definitions for the ZBT stream arbiter: default ZBT bus widths and
// the arbitration FSM state encoding.
package zbt_stream_arbiter_pkg;

  localparam int ZBT_ADDR_W = 19;
  localparam int ZBT_DATA_W = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/zbt_stream_arbiter_read_tag_pipe.sv
// Read-return path: a RD_LAT-deep valid tag shift register with synchronous
// flush, plus the capture register for ZBT read data. The SRAM is expected to
// present the word RD_LAT-1 cycles after its address; the capture register
// supplies the last cycle so Rd_Data_Valid_O lands RD_LAT cycles after the ack.
module zbt_read_tag_pipe
  import zbt_stream_arbiter_pkg::*;
#(
  parameter int RD_LAT = 2,
  parameter int DATA_W = ZBT_DATA_W
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              i_flush,
  input  logic              i_tag,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid
);

  logic [RD_LAT-1:0] r_tag;
  logic [DATA_W-1:0] r_data;

  // Shift issued-read tags toward the output; a flush drops everything in flight
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)      r_tag <= '0;
    else if (i_flush) r_tag <= '0;
    else              r_tag <= (r_tag << 1) | RD_LAT'(i_tag);
  end

  // Capture SRAM read data every cycle; the tag says when it is meaningful
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_data <= '0;
    else         r_data <= i_data;
  end

  assign o_data  = r_data;
  assign o_valid = r_tag[RD_LAT-1];

endmodule

// File: rtl/zbt_stream_arbiter.sv
// Single-port ZBT SRAM controller sharing the SRAM between the Ethernet burst
// writer and the bitstream read buffer. Owns the circular write/read pointers,
// the fill level and the sticky initial-fill flag.
// Optional build macro ZBT_ARB_STATS_EN adds saturating write/read stall
// counters on Stat_Wr_Stall_O / Stat_Rd_Stall_O.
module zbt_stream_arbiter
  import zbt_stream_arbiter_pkg::*;
#(
  parameter int ADDR_W      = ZBT_ADDR_W,
  parameter int DATA_W      = ZBT_DATA_W,
  parameter int WR_BURST    = 16,
  parameter int RD_BURST    = 4,
  parameter int RD_LAT      = 2,
  parameter int HIGH_WM     = (1 << ADDR_W) - 64,
  parameter int FILL_THRESH = 1 << (ADDR_W - 1)
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              Reset_Address_I,
  input  logic              Wr_Valid_I,
  input  logic [DATA_W-1:0] Wr_Data_I,
  output logic              Wr_Ready_O,
  input  logic              Rd_Req_I,
  output logic              Rd_Ack_O,
  output logic [DATA_W-1:0] Rd_Data_O,
  output logic              Rd_Data_Valid_O,
  output logic [ADDR_W-1:0] ZBT_Address_O,
  output logic [DATA_W-1:0] ZBT_Data_O,
  output logic              ZBT_Write_En_O,
  input  logic [DATA_W-1:0] ZBT_Data_I,
  output logic [ADDR_W:0]   Fill_Level_O,
  output logic              Empty_O,
  output logic              Full_O,
  output logic              Initial_Fill_O
`ifdef ZBT_ARB_STATS_EN
  ,
  output logic [15:0]       Stat_Wr_Stall_O,
  output logic [15:0]       Stat_Rd_Stall_O
`endif
);

  localparam int LVL_W   = ADDR_W + 1;
  localparam int BURST_W = $clog2(((WR_BURST > RD_BURST) ? WR_BURST : RD_BURST) + 1);
  localparam logic [LVL_W-1:0]   DEPTH     = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [BURST_W-1:0] WR_LAST   = BURST_W'(WR_BURST - 1);
  localparam logic [BURST_W-1:0] RD_LAST   = BURST_W'(RD_BURST - 1);
  localparam logic [LVL_W-1:0]   HWM_LVL   = LVL_W'(HIGH_WM);
  localparam logic [LVL_W-1:0]   THRESH    = LVL_W'(FILL_THRESH);

  arb_state_t          r_state;
  logic [BURST_W-1:0]  r_burst;
  // Counters are one bit wider than the pointers so their difference is the level
  logic [LVL_W-1:0]    r_wr_cnt;
  logic [LVL_W-1:0]    r_rd_cnt;
  logic                r_init_fill;

  logic [LVL_W-1:0]    w_level;
  logic                w_empty;
  logic                w_full;
  logic                w_wr_ready;
  logic                w_wr_fire;
  logic                w_rd_ack;
  logic                w_wr_elig;
  logic                w_rd_elig;

  assign w_level    = r_wr_cnt - r_rd_cnt;
  assign w_empty    = (w_level == '0);
  assign w_full     = (w_level == DEPTH);
  // Ready depends only on state and level so the writer can use it combinationally
  assign w_wr_ready = (r_state == S_WRITE) && !w_full && !Reset_Address_I;
  assign w_wr_fire  = w_wr_ready && Wr_Valid_I;
  assign w_rd_ack   = (r_state == S_READ) && Rd_Req_I && !w_empty && !Reset_Address_I;
  // Near the top of the ring a waiting reader gets precedence over the writer
  assign w_wr_elig  = Wr_Valid_I && !w_full && ((w_level < HWM_LVL) || !Rd_Req_I);
  assign w_rd_elig  = Rd_Req_I && !w_empty;

  // Arbitration FSM: bursts are bounded so neither side can starve the other
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_burst <= '0;
    end else if (Reset_Address_I) begin
      r_state <= S_IDLE;
      r_burst <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_burst <= '0;
          if (w_wr_elig)      r_state <= S_WRITE;
          else if (w_rd_elig) r_state <= S_READ;
        end
        S_WRITE: begin
          if (w_wr_fire) r_burst <= r_burst + 1'b1;
          if (!Wr_Valid_I || w_full || (w_wr_fire && (r_burst == WR_LAST))) begin
            r_burst <= '0;
            r_state <= w_rd_elig ? S_READ : S_IDLE;
          end
        end
        S_READ: begin
          if (w_rd_ack) r_burst <= r_burst + 1'b1;
          if (!Rd_Req_I || w_empty || (w_rd_ack && (r_burst == RD_LAST))) begin
            r_burst <= '0;
            r_state <= w_wr_elig ? S_WRITE : S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_burst <= '0;
        end
      endcase
    end
  end

  // Ring pointers and the sticky initial-fill flag
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_init_fill <= 1'b0;
    end else if (Reset_Address_I) begin
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_init_fill <= 1'b0;
    end else begin
      if (w_wr_fire) r_wr_cnt <= r_wr_cnt + 1'b1;
      if (w_rd_ack)  r_rd_cnt <= r_rd_cnt + 1'b1;
      if (w_level >= THRESH) r_init_fill <= 1'b1;
    end
  end

  zbt_read_tag_pipe #(
    .RD_LAT (RD_LAT),
    .DATA_W (DATA_W)
  ) u_tag_pipe (
    .clock   (clock),
    .resetn  (resetn),
    .i_flush (Reset_Address_I),
    .i_tag   (w_rd_ack),
    .i_data  (ZBT_Data_I),
    .o_data  (Rd_Data_O),
    .o_valid (Rd_Data_Valid_O)
  );

  // With no access in progress the address bus parks on the read pointer
  assign ZBT_Address_O  = w_wr_fire ? r_wr_cnt[ADDR_W-1:0] : r_rd_cnt[ADDR_W-1:0];
  assign ZBT_Data_O     = w_wr_fire ? Wr_Data_I : '0;
  assign ZBT_Write_En_O = w_wr_fire;
  assign Wr_Ready_O     = w_wr_ready;
  assign Rd_Ack_O       = w_rd_ack;
  assign Fill_Level_O   = w_level;
  assign Empty_O        = w_empty;
  assign Full_O         = w_full;
  assign Initial_Fill_O = r_init_fill;

`ifdef ZBT_ARB_STATS_EN
  logic [15:0] r_wr_stall;
  logic [15:0] r_rd_stall;

  // Saturating counts of cycles where a requester was kept waiting
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wr_stall <= '0;
      r_rd_stall <= '0;
    end else if (Reset_Address_I) begin
      r_wr_stall <= '0;
      r_rd_stall <= '0;
    end else begin
      if (Wr_Valid_I && !w_wr_ready && (r_wr_stall != 16'hFFFF))
        r_wr_stall <= r_wr_stall + 16'd1;
      if (Rd_Req_I && !w_rd_ack && (r_rd_stall != 16'hFFFF))
        r_rd_stall <= r_rd_stall + 16'd1;
    end
  end

  assign Stat_Wr_Stall_O = r_wr_stall;
  assign Stat_Rd_Stall_O = r_rd_stall;
`endif

endmodule

// File: tb/tb_zbt_stream_arbiter.sv
// Testbench for zbt_stream_arbiter with a reduced ring (ADDR_W=8) so the wrap
// and full cases fit in a short run. A negedge monitor keeps a FIFO-level
// reference of the ring contents and scores every access and read return.
module tb_zbt_stream_arbiter;

  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int WRB   = 16;
  localparam int RDB   = 4;
  localparam int RDL   = 2;
  localparam int DEPTH = 1 << AW;
  localparam int HWM   = DEPTH - 64;
  localparam int THR   = DEPTH / 2;
  localparam byte KW   = "W";
  localparam byte KR   = "R";

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          Reset_Address_I = 1'b0;
  logic          Wr_Valid_I = 1'b0;
  logic [DW-1:0] Wr_Data_I = '0;
  logic          Wr_Ready_O;
  logic          Rd_Req_I = 1'b0;
  logic          Rd_Ack_O;
  logic [DW-1:0] Rd_Data_O;
  logic          Rd_Data_Valid_O;
  logic [AW-1:0] ZBT_Address_O;
  logic [DW-1:0] ZBT_Data_O;
  logic          ZBT_Write_En_O;
  logic [DW-1:0] ZBT_Data_I = '0;
  logic [AW:0]   Fill_Level_O;
  logic          Empty_O;
  logic          Full_O;
  logic          Initial_Fill_O;
`ifdef ZBT_ARB_STATS_EN
  logic [15:0]   Stat_Wr_Stall_O;
  logic [15:0]   Stat_Rd_Stall_O;
`endif

  always #5 clock = ~clock;

  zbt_stream_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .WR_BURST(WRB), .RD_BURST(RDB), .RD_LAT(RDL),
    .HIGH_WM(HWM), .FILL_THRESH(THR)
  ) dut (
    .clock(clock), .resetn(resetn), .Reset_Address_I(Reset_Address_I),
    .Wr_Valid_I(Wr_Valid_I), .Wr_Data_I(Wr_Data_I), .Wr_Ready_O(Wr_Ready_O),
    .Rd_Req_I(Rd_Req_I), .Rd_Ack_O(Rd_Ack_O), .Rd_Data_O(Rd_Data_O),
    .Rd_Data_Valid_O(Rd_Data_Valid_O), .ZBT_Address_O(ZBT_Address_O),
    .ZBT_Data_O(ZBT_Data_O), .ZBT_Write_En_O(ZBT_Write_En_O), .ZBT_Data_I(ZBT_Data_I),
    .Fill_Level_O(Fill_Level_O), .Empty_O(Empty_O), .Full_O(Full_O),
    .Initial_Fill_O(Initial_Fill_O)
`ifdef ZBT_ARB_STATS_EN
    , .Stat_Wr_Stall_O(Stat_Wr_Stall_O), .Stat_Rd_Stall_O(Stat_Rd_Stall_O)
`endif
  );

  // SRAM model: data appears RD_LAT-1 cycles after the address
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clock) begin
    if (ZBT_Write_En_O) mem[ZBT_Address_O] <= ZBT_Data_O;
    ZBT_Data_I <= mem[ZBT_Address_O];
  end

  int checks = 0;
  int errors = 0;

  function automatic void chk(string nm, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endfunction

  // Reference state
  typedef struct { logic [DW-1:0] d; int due; } rd_exp_t;
  logic [DW-1:0] mq[$];
  rd_exp_t       sbq[$];
  int  cyc = 0, m_level = 0, m_wptr = 0, m_rptr = 0;
  bit  m_init = 1'b0;
  int  n_wr = 0, n_ack = 0, last_waddr = -1;
  int  wlog[$], alog[$], klog_c[$];
  byte klog_k[$];
  int  m_sw = 0, m_sr = 0;

  // Monitor: compare against the reference, then advance it by this cycle's events
  always @(negedge clock) begin
    if (resetn) begin
      bit wf, ra;
      rd_exp_t e;
      wf = Wr_Valid_I && Wr_Ready_O;
      ra = Rd_Ack_O;
      chk("level", int'(Fill_Level_O), m_level);
      chk("empty", int'(Empty_O), int'(m_level == 0));
      chk("full", int'(Full_O), int'(m_level == DEPTH));
      chk("init_fill", int'(Initial_Fill_O), int'(m_init));
      if (m_level == DEPTH || Reset_Address_I) chk("wr_ready_blocked", int'(Wr_Ready_O), 0);
      if (m_level == 0 || Reset_Address_I || !Rd_Req_I) chk("ack_blocked", int'(Rd_Ack_O), 0);
      chk("wr_en", int'(ZBT_Write_En_O), int'(wf));
      chk("one_access", int'(wf && ra), 0);
      if (wf) begin
        chk("wr_addr", int'(ZBT_Address_O), m_wptr);
        chk("wr_data", int'(ZBT_Data_O), int'(Wr_Data_I));
      end else begin
        chk("rd_or_idle_addr", int'(ZBT_Address_O), m_rptr);
      end
      if (Rd_Data_Valid_O) begin
        chk("rd_valid_expected", int'(sbq.size() > 0), 1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          chk("rd_data", int'(Rd_Data_O), int'(e.d));
          chk("rd_latency", cyc, e.due);
        end
      end
      while (sbq.size() > 0 && sbq[0].due < cyc) begin
        chk("rd_valid_missing_due", sbq[0].due, cyc);
        void'(sbq.pop_front());
      end
`ifdef ZBT_ARB_STATS_EN
      chk("stat_wr", int'(Stat_Wr_Stall_O), m_sw);
      chk("stat_rd", int'(Stat_Rd_Stall_O), m_sr);
`endif
      if (m_level >= THR) m_init = 1'b1;
      if (Reset_Address_I) begin
        m_level = 0; m_wptr = 0; m_rptr = 0; m_init = 1'b0;
        mq.delete(); sbq.delete(); m_sw = 0; m_sr = 0;
      end else begin
        if (Wr_Valid_I && !Wr_Ready_O && m_sw != 65535) m_sw++;
        if (Rd_Req_I && !Rd_Ack_O && m_sr != 65535) m_sr++;
        if (wf) begin
          mq.push_back(Wr_Data_I);
          m_wptr = (m_wptr + 1) % DEPTH;
          m_level++; n_wr++;
          last_waddr = int'(ZBT_Address_O);
          wlog.push_back(cyc); klog_k.push_back(KW); klog_c.push_back(cyc);
        end
        if (ra && mq.size() > 0) begin
          e.d = mq.pop_front();
          e.due = cyc + RDL;
          sbq.push_back(e);
          m_rptr = (m_rptr + 1) % DEPTH;
          m_level--; n_ack++;
          alog.push_back(cyc); klog_k.push_back(KR); klog_c.push_back(cyc);
        end
      end
      cyc++;
    end
  end

  // Driver state
  int wr_left = 0, seen_wr = 0;
  bit rnd_mode = 1'b0;

  task automatic step();
    @(posedge clock); #1;
    if (n_wr != seen_wr) begin
      seen_wr = n_wr;
      if (wr_left > 0) wr_left--;
      Wr_Data_I = $urandom;
    end
    if (rnd_mode) begin
      Wr_Valid_I      = ($urandom_range(0, 3) != 0);
      Rd_Req_I        = ($urandom_range(0, 2) != 0);
      Reset_Address_I = ($urandom_range(0, 299) == 0);
    end else begin
      Wr_Valid_I = (wr_left > 0);
    end
  endtask

  task automatic rst_addr();
    Reset_Address_I = 1'b1;
    step();
    Reset_Address_I = 1'b0;
    step();
  endtask

  byte run_k[$];
  int  run_l[$];
  task automatic build_runs();
    run_k.delete(); run_l.delete();
    for (int i = 0; i < klog_k.size(); i++) begin
      if (i > 0 && klog_k[i] == klog_k[i-1] && klog_c[i] == klog_c[i-1] + 1)
        run_l[run_l.size()-1] = run_l[run_l.size()-1] + 1;
      else begin
        run_k.push_back(klog_k[i]);
        run_l.push_back(1);
      end
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog cycles=%0d required=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int start, base_w, base_a;
    byte ek[4];
    int  el[4];

    // Reset state with live inputs
    Wr_Valid_I = 1'b1; Wr_Data_I = $urandom; Rd_Req_I = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_wr_ready", int'(Wr_Ready_O), 0);
    chk("rst_rd_ack", int'(Rd_Ack_O), 0);
    chk("rst_rd_data", int'(Rd_Data_O), 0);
    chk("rst_rd_valid", int'(Rd_Data_Valid_O), 0);
    chk("rst_addr", int'(ZBT_Address_O), 0);
    chk("rst_zbt_data", int'(ZBT_Data_O), 0);
    chk("rst_we", int'(ZBT_Write_En_O), 0);
    chk("rst_level", int'(Fill_Level_O), 0);
    chk("rst_empty", int'(Empty_O), 1);
    chk("rst_full", int'(Full_O), 0);
    chk("rst_init", int'(Initial_Fill_O), 0);
    @(posedge clock); #1;
    resetn = 1'b1; Wr_Valid_I = 1'b0; Rd_Req_I = 1'b0;
    step();

    // 1: 20 words, no reader -> 16 writes, one idle cycle, 4 writes
    wr_left = 20; Wr_Valid_I = 1'b1; start = cyc; wlog.delete();
    repeat (30) step();
    chk("t1_nwrites", wlog.size(), 20);
    for (int i = 0; i < 20 && i < wlog.size(); i++)
      chk("t1_write_cycle", wlog[i] - start, (i < 16) ? i + 1 : i + 2);
    chk("t1_level", int'(Fill_Level_O), 20);

    // 2: drain with reader held high -> bursts of 4 acks separated by idle cycles
    alog.delete(); start = cyc; Rd_Req_I = 1'b1;
    repeat (35) step();
    Rd_Req_I = 1'b0;
    repeat (4) step();
    chk("t2_nacks", alog.size(), 20);
    for (int i = 0; i < 20 && i < alog.size(); i++)
      chk("t2_ack_cycle", alog[i] - start, 1 + (i / 4) * 5 + (i % 4));
    chk("t2_empty", int'(Empty_O), 1);

    // 3a: at the high watermark with both sides active, the read goes first
    rst_addr();
    wr_left = HWM; Wr_Valid_I = 1'b1;
    for (int k = 0; k < 400 && wr_left > 0; k++) step();
    repeat (3) step();
    chk("t3a_level", int'(Fill_Level_O), HWM);
    klog_k.delete(); klog_c.delete(); start = cyc;
    wr_left = 1 << 30; Wr_Valid_I = 1'b1; Rd_Req_I = 1'b1;
    repeat (30) step();
    wr_left = 0; Wr_Valid_I = 1'b0; Rd_Req_I = 1'b0;
    repeat (4) step();
    build_runs();
    chk("t3a_first_access_cycle", (klog_c.size() > 0) ? klog_c[0] - start : -1, 1);
    chk("t3a_nruns", int'(run_k.size() >= 2), 1);
    if (run_k.size() >= 2) begin
      chk("t3a_run0_kind", int'(run_k[0]), int'(KR));
      chk("t3a_run0_len", run_l[0], RDB);
      chk("t3a_run1_kind", int'(run_k[1]), int'(KW));
      chk("t3a_run1_len", run_l[1], WRB);
    end

    // 3b: below the watermark writes win and bursts alternate back to back
    rst_addr();
    klog_k.delete(); klog_c.delete(); start = cyc;
    wr_left = 1 << 30; Wr_Valid_I = 1'b1; Rd_Req_I = 1'b1;
    repeat (48) step();
    wr_left = 0; Wr_Valid_I = 1'b0; Rd_Req_I = 1'b0;
    repeat (4) step();
    build_runs();
    ek = '{KW, KR, KW, KR};
    el = '{WRB, RDB, WRB, RDB};
    chk("t3b_nruns", int'(run_k.size() >= 4), 1);
    for (int i = 0; i < 4 && i < run_k.size(); i++) begin
      chk("t3b_run_kind", int'(run_k[i]), int'(ek[i]));
      chk("t3b_run_len", run_l[i], el[i]);
    end

    // 4: fill the ring completely, then one read frees a slot and the write wraps
    rst_addr();
    wr_left = DEPTH + 5; Wr_Valid_I = 1'b1;
    repeat (320) step();
    chk("t4_level_full", int'(Fill_Level_O), DEPTH);
    chk("t4_full", int'(Full_O), 1);
    chk("t4_wr_ready", int'(Wr_Ready_O), 0);
    chk("t4_words_left", wr_left, 5);
    chk("t4_init_fill", int'(Initial_Fill_O), 1);
    base_w = n_wr; base_a = n_ack; Rd_Req_I = 1'b1;
    for (int k = 0; k < 20 && n_ack == base_a; k++) step();
    Rd_Req_I = 1'b0;
    repeat (10) step();
    chk("t4_one_more_write", n_wr - base_w, 1);
    chk("t4_wrap_addr", last_waddr, 0);
    chk("t4_level_back", int'(Fill_Level_O), DEPTH);
    wr_left = 0; Wr_Valid_I = 1'b0;
    step();

    // 5: address reset one cycle after an ack kills the pending return
    base_a = n_ack; Rd_Req_I = 1'b1;
    for (int k = 0; k < 20 && n_ack == base_a; k++) step();
    Reset_Address_I = 1'b1; Rd_Req_I = 1'b0;
    step();
    Reset_Address_I = 1'b0;
    repeat (5) step();
    chk("t5_ack_seen", n_ack - base_a, 1);
    chk("t5_level", int'(Fill_Level_O), 0);
    chk("t5_init", int'(Initial_Fill_O), 0);
    chk("t5_empty", int'(Empty_O), 1);
    base_w = n_wr; wr_left = 1; Wr_Valid_I = 1'b1;
    repeat (6) step();
    chk("t5_write_count", n_wr - base_w, 1);
    chk("t5_write_addr", last_waddr, 0);

    // Random traffic with occasional address resets
    rst_addr();
    wr_left = 0; rnd_mode = 1'b1;
    repeat (3000) step();
    rnd_mode = 1'b0; Wr_Valid_I = 1'b0; Rd_Req_I = 1'b0; Reset_Address_I = 1'b0;
    repeat (10) step();

`ifdef ZBT_ARB_STATS_EN
    // 6: a writer stalled against a full ring saturates the stall counter
    rst_addr();
    wr_left = 1 << 30; Wr_Valid_I = 1'b1;
    repeat (70300) step();
    chk("t6_wr_stall_sat", int'(Stat_Wr_Stall_O), 65535);
    wr_left = 0; Wr_Valid_I = 1'b0;
    repeat (3) step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
